// File: rtl/rf_access_sched.sv
// Register-file access scheduler: an in-order read queue issued over two read
// ports, plus a one-entry pending write with a starvation guard that freezes reads.
module rf_access_sched #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned RQ_DEPTH   = 4,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [ADDR_WIDTH-1:0] rf_wad1,
  output logic                  rf_wen1,
  output logic [ADDR_WIDTH-1:0] rf_rad1,
  output logic [ADDR_WIDTH-1:0] rf_rad2,
  output logic                  rf_ren1,
  output logic                  rf_ren2,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2,
  input  logic                  rf_collision,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  err
);

  localparam int unsigned PW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;
  localparam int unsigned CW = $clog2(RQ_DEPTH + 1);
  localparam int unsigned SW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;

  logic [ADDR_WIDTH-1:0] rq [RQ_DEPTH];
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         wr_ptr;
  logic [CW-1:0]         count;
  logic                  wr_pend;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [SW-1:0]         starve_cnt;
  logic                  rsp0_q;
  logic                  rsp1_q;
  logic                  err_q;

  logic [ADDR_WIDTH-1:0] h0;
  logic [ADDR_WIDTH-1:0] h1;
  logic                  freeze;
  logic                  iss0;
  logic                  iss1;
  logic                  issw;
  logic                  push;
  logic [CW-1:0]         pop_n;

  // Issue decision: reads from the queue head, the write only when it cannot clash.
  always_comb begin
    h0     = rq[rd_ptr];
    h1     = rq[rd_ptr + PW'(1)];
    freeze = (starve_cnt == SW'(STARVE_LIM));
    iss0   = resetn && (count != '0) && !freeze;
    iss1   = iss0 && (count >= CW'(2)) && (h1 != h0) &&
             !(wr_pend && (h1 == wr_addr_q));
    issw   = resetn && wr_pend && !(iss0 && (h0 == wr_addr_q));
    pop_n  = iss1 ? CW'(2) : (iss0 ? CW'(1) : '0);
  end

  assign rd_ready = !resetn || (count < CW'(RQ_DEPTH));
  assign wr_ready = !resetn || !wr_pend || issw;
  assign push     = resetn && rd_valid && rd_ready;

  assign rf_ren1 = iss0;
  assign rf_rad1 = iss0 ? h0 : '0;
  assign rf_ren2 = iss1;
  assign rf_rad2 = iss1 ? h1 : '0;
  assign rf_wen1 = issw;
  assign rf_wad1 = issw ? wr_addr_q : '0;
  assign rf_din  = issw ? wr_data_q : '0;

  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp0_data  = rsp0_q ? rf_dout1 : '0;
  assign rsp1_data  = rsp1_q ? rf_dout2 : '0;
  assign err        = err_q;

  // Queue storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) rq[wr_ptr] <= rd_addr;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      wr_pend    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      starve_cnt <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_ptr + PW'(pop_n);
      count  <= count + CW'(push) - pop_n;

      if (wr_valid && wr_ready) begin
        wr_pend   <= 1'b1;
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end else if (issw) begin
        wr_pend <= 1'b0;
      end

      // Counts cycles the pending write loses to reads; saturates at the freeze level.
      if (!wr_pend || issw)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIM))
        starve_cnt <= starve_cnt + SW'(1);

      rsp0_q <= iss0;
      rsp1_q <= iss1;
      if (rf_collision) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_access_sched.sv
// Bench for rf_access_sched: behavioural register file, response scoreboard,
// and one task per scenario.
module tb_rf_access_sched;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned RQD = 4;
  localparam int unsigned SL  = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_ready;
  logic [DW-1:0] rf_din;
  logic [AW-1:0] rf_wad1;
  logic          rf_wen1;
  logic [AW-1:0] rf_rad1;
  logic [AW-1:0] rf_rad2;
  logic          rf_ren1;
  logic          rf_ren2;
  logic [DW-1:0] rf_dout1;
  logic [DW-1:0] rf_dout2;
  logic          rf_collision;
  logic          rsp0_valid;
  logic          rsp1_valid;
  logic [DW-1:0] rsp0_data;
  logic [DW-1:0] rsp1_data;
  logic          err;

  logic [DW-1:0] mem [32];
  logic          preload;
  logic [DW-1:0] exp_q [$];
  int            n_cmp;
  int            n_bad;

  always #5 clk = ~clk;

  rf_access_sched #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RQ_DEPTH(RQD), .STARVE_LIM(SL)
  ) dut (
    .clk(clk), .resetn(resetn),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rf_din(rf_din), .rf_wad1(rf_wad1), .rf_wen1(rf_wen1),
    .rf_rad1(rf_rad1), .rf_rad2(rf_rad2), .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
    .rf_dout1(rf_dout1), .rf_dout2(rf_dout2), .rf_collision(rf_collision),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_data(rsp0_data), .rsp1_data(rsp1_data), .err(err)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 3) return DW'(32'hA);
    if (i == 7) return DW'(32'hB);
    return DW'(32'h100) + DW'(i);
  endfunction

  // Register file with registered read data; a same-edge write is seen next cycle.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      rf_dout1 <= '0;
      rf_dout2 <= '0;
    end else begin
      if (rf_ren1) rf_dout1 <= mem[rf_rad1];
      if (rf_ren2) rf_dout2 <= mem[rf_rad2];
      if (rf_wen1) mem[rf_wad1] <= rf_din;
    end
  end

  // Advance to the next falling edge, then check port exclusivity and scoreboard.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clk);
    n_cmp++;
    if ((rf_ren1 && rf_ren2 && rf_rad1 == rf_rad2) ||
        (rf_wen1 && rf_ren1 && rf_wad1 == rf_rad1) ||
        (rf_wen1 && rf_ren2 && rf_wad1 == rf_rad2) ||
        (rsp1_valid && !rsp0_valid)) begin
      n_bad++;
      $display("FAIL port_overlap: wen=%b wad=%0d ren=%b%b rad=%0d/%0d rspv=%b%b, required disjoint ports",
               rf_wen1, rf_wad1, rf_ren1, rf_ren2, rf_rad1, rf_rad2, rsp0_valid, rsp1_valid);
    end
    if (rsp0_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp0_unexpected: got %h, required no response", rsp0_data);
      end else begin
        e = exp_q.pop_front();
        if (rsp0_data !== e) begin
          n_bad++;
          $display("FAIL rsp0_data: got %h, required %h", rsp0_data, e);
        end
      end
    end
    if (rsp1_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rsp1_unexpected: got %h, required no response", rsp1_data);
      end else begin
        e = exp_q.pop_front();
        if (rsp1_data !== e) begin
          n_bad++;
          $display("FAIL rsp1_data: got %h, required %h", rsp1_data, e);
        end
      end
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      tick();
      i++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic send_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    int i;
    i = 0;
    rd_valid = 1'b1;
    rd_addr  = a;
    while (!rd_ready && i < 50) begin
      tick();
      i++;
    end
    n_cmp++;
    if (!rd_ready) begin
      n_bad++;
      $display("FAIL rd_accept: rd_ready=%b, required 1 within 50 cycles", rd_ready);
    end else begin
      exp_q.push_back(e);
    end
    tick();
    rd_valid = 1'b0;
    rd_addr  = '0;
  endtask

  task automatic test_reset();
    resetn  = 1'b0;
    preload = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({rf_wen1, rf_ren1, rf_ren2, rd_ready, wr_ready} !== 5'b00011) begin
      n_bad++;
      $display("FAIL in_reset_flags: got %b, required 00011",
               {rf_wen1, rf_ren1, rf_ren2, rd_ready, wr_ready});
    end
    n_cmp++;
    if ({rf_din, rf_wad1, rf_rad1, rf_rad2} !== '0) begin
      n_bad++;
      $display("FAIL in_reset_bus: din=%h wad=%0d rad=%0d/%0d, required all 0",
               rf_din, rf_wad1, rf_rad1, rf_rad2);
    end
    preload = 1'b0;
    resetn  = 1'b1;
    tick();
    n_cmp++;
    if ({rf_wen1, rf_ren1, rf_ren2, rd_ready, wr_ready, rsp0_valid, rsp1_valid, err} !== 8'b00011000) begin
      n_bad++;
      $display("FAIL post_reset_flags: got %b, required 00011000",
               {rf_wen1, rf_ren1, rf_ren2, rd_ready, wr_ready, rsp0_valid, rsp1_valid, err});
    end
  endtask

  task automatic test_latency();
    rd_valid = 1'b1;
    rd_addr  = AW'(4);
    exp_q.push_back(init_val(4));
    tick();
    rd_valid = 1'b0;
    n_cmp++;
    if ({rf_ren1, rf_ren2, rf_rad1} !== {2'b10, AW'(4)}) begin
      n_bad++;
      $display("FAIL latency_issue: ren=%b%b rad1=%0d, required ren=10 rad1=4", rf_ren1, rf_ren2, rf_rad1);
    end
    tick();
    n_cmp++;
    if ({rsp0_valid, rsp1_valid, rsp0_data} !== {2'b10, init_val(4)}) begin
      n_bad++;
      $display("FAIL latency_rsp: v=%b%b data=%h, required v=10 data=%h",
               rsp0_valid, rsp1_valid, rsp0_data, init_val(4));
    end
    drain();
  endtask

  // A write to 3 stalls behind a stream of reads of 3 until the freeze; 7 then queues behind 3.
  task automatic test_dual_issue();
    int frozen_at;
    frozen_at = -1;
    wr_valid = 1'b1;
    wr_addr  = AW'(3);
    wr_data  = DW'(32'hA);
    rd_valid = 1'b1;
    rd_addr  = AW'(3);
    exp_q.push_back(DW'(32'hA));
    for (int i = 1; i <= 20 && frozen_at < 0; i++) begin
      tick();
      wr_valid = 1'b0;
      if (rf_wen1) begin
        frozen_at = i;
        n_cmp++;
        if ({rf_ren1, rf_ren2, rf_wad1, rf_din} !== {2'b00, AW'(3), DW'(32'hA)}) begin
          n_bad++;
          $display("FAIL frozen_cycle: ren=%b%b wad=%0d din=%h, required ren=00 wad=3 din=a",
                   rf_ren1, rf_ren2, rf_wad1, rf_din);
        end
        rd_addr = AW'(7);
        exp_q.push_back(DW'(32'hB));
      end else begin
        exp_q.push_back(DW'(32'hA));
      end
    end
    n_cmp++;
    if (frozen_at != int'(SL) + 1) begin
      n_bad++;
      $display("FAIL freeze_timing: write issued in cycle %0d, required %0d", frozen_at, SL + 1);
    end
    tick();
    rd_valid = 1'b0;
    n_cmp++;
    if ({rf_ren1, rf_ren2, rf_rad1, rf_rad2} !== {2'b11, AW'(3), AW'(7)}) begin
      n_bad++;
      $display("FAIL dual_issue: ren=%b%b rad=%0d/%0d, required ren=11 rad=3/7",
               rf_ren1, rf_ren2, rf_rad1, rf_rad2);
    end
    drain();
  endtask

  task automatic test_same_addr();
    int issues;
    int dual;
    issues = 0;
    dual   = 0;
    rd_valid = 1'b1;
    rd_addr  = AW'(5);
    exp_q.push_back(init_val(5));
    for (int j = 0; j < 6; j++) begin
      tick();
      if (j == 0) exp_q.push_back(init_val(5));
      else rd_valid = 1'b0;
      if (rf_ren1 && rf_rad1 == AW'(5)) issues++;
      if (rf_ren2) dual++;
    end
    n_cmp++;
    if (issues != 2 || dual != 0) begin
      n_bad++;
      $display("FAIL same_addr: port1 issues=%0d port2 issues=%0d, required 2 and 0", issues, dual);
    end
    drain();
  endtask

  task automatic test_raw_hazard();
    wr_valid = 1'b1;
    wr_addr  = AW'(9);
    wr_data  = DW'(32'h55);
    rd_valid = 1'b1;
    rd_addr  = AW'(9);
    exp_q.push_back(init_val(9));
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    n_cmp++;
    if ({rf_ren1, rf_rad1, rf_wen1} !== {1'b1, AW'(9), 1'b0}) begin
      n_bad++;
      $display("FAIL raw_read_first: ren1=%b rad1=%0d wen1=%b, required 1/9/0", rf_ren1, rf_rad1, rf_wen1);
    end
    tick();
    n_cmp++;
    if ({rf_wen1, rf_wad1, rf_din, rf_ren1} !== {1'b1, AW'(9), DW'(32'h55), 1'b0}) begin
      n_bad++;
      $display("FAIL raw_write_next: wen1=%b wad1=%0d din=%h ren1=%b, required 1/9/55/0",
               rf_wen1, rf_wad1, rf_din, rf_ren1);
    end
    drain();
    send_read(AW'(9), DW'(32'h55));
    drain();
  endtask

  // Reads of 2 and writes of 2 offered every cycle; each freeze grows the queue by one.
  task automatic test_starve();
    int writes;
    int last_w;
    int full_seen;
    writes    = 0;
    last_w    = 0;
    full_seen = 0;
    rd_valid  = 1'b1;
    rd_addr   = AW'(2);
    wr_valid  = 1'b1;
    wr_addr   = AW'(2);
    wr_data   = init_val(2);
    for (int i = 0; i < 200 && full_seen == 0; i++) begin
      if (rf_wen1) begin
        writes++;
        n_cmp++;
        if (rf_ren1 || rf_ren2 || (i - last_w) != int'(SL) + 1) begin
          n_bad++;
          $display("FAIL starve_freeze: ren=%b%b gap=%0d, required ren=00 gap=%0d",
                   rf_ren1, rf_ren2, i - last_w, SL + 1);
        end
        last_w = i;
      end
      if (!rd_ready) begin
        full_seen = 1;
      end else begin
        exp_q.push_back(init_val(2));
        tick();
      end
    end
    rd_valid = 1'b0;
    wr_valid = 1'b0;
    n_cmp++;
    if (full_seen != 1 || writes != int'(RQD) - 1) begin
      n_bad++;
      $display("FAIL starve_fill: full_seen=%0d freezes=%0d, required 1 and %0d", full_seen, writes, RQD - 1);
    end
    drain();
    n_cmp++;
    if ({wr_ready, rd_ready} !== 2'b11) begin
      n_bad++;
      $display("FAIL starve_recover: wr_ready=%b rd_ready=%b, required 1 1", wr_ready, rd_ready);
    end
  endtask

  task automatic test_err();
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_initial: got %b, required 0", err);
    end
    rf_collision = 1'b1;
    tick();
    rf_collision = 1'b0;
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set: got %b, required 1", err);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    rd_valid = 1'b1;
    for (int k = 10; k < 13; k++) begin
      rd_addr = AW'(k);
      exp_q.push_back(init_val(k));
      tick();
    end
    rd_valid = 1'b0;
    resetn   = 1'b0;
    tick();
    exp_q.delete();
    n_cmp++;
    if ({rsp0_valid, rsp1_valid, rf_ren1, rf_wen1, rd_ready, err} !== 6'b000010) begin
      n_bad++;
      $display("FAIL mid_reset: rspv=%b%b ren1=%b wen1=%b rd_ready=%b err=%b, required 000010",
               rsp0_valid, rsp1_valid, rf_ren1, rf_wen1, rd_ready, err);
    end
    resetn = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (rsp0_valid || rsp1_valid || rf_ren1 || rf_ren2 || rf_wen1) stray++;
    end
    n_cmp++;
    if (stray != 0) begin
      n_bad++;
      $display("FAIL post_mid_reset: %0d cycles with activity, required 0", stray);
    end
    send_read(AW'(13), init_val(13));
    drain();
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    preload      = 1'b1;
    resetn       = 1'b0;
    wr_valid     = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    rd_valid     = 1'b0;
    rd_addr      = '0;
    rf_collision = 1'b0;
    test_reset();
    test_latency();
    test_dual_issue();
    test_same_addr();
    test_raw_hazard();
    test_starve();
    test_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/rf_access_sched.md
RF_ACCESS_SCHED -- requirements
Module: rf_access_sched

Interface
REQ-001 Parameters SHALL be DATA_WIDTH, default 32, register data width; ADDR_WIDTH, default 5, register address width; RQ_DEPTH, default 4, read-queue entries, a power of 2 and at least 2; STARVE_LIM, default 4, write-stall cycles before reads freeze.
REQ-002 Ports SHALL be, in order (name  direction  width  meaning):
  clk  in  1  clock; resetn is synchronous, active-low; clock clk
  resetn  in  1  synchronous active-low reset
  wr_valid  in  1  write request valid
  wr_addr  in  ADDR_WIDTH  write address
  wr_data  in  DATA_WIDTH  write data
  wr_ready  out  1  write request accepted when wr_valid && wr_ready at posedge
  rd_valid  in  1  read request valid
  rd_addr  in  ADDR_WIDTH  read address
  rd_ready  out  1  read request accepted when rd_valid && rd_ready at posedge
  rf_din  out  DATA_WIDTH  register-file write data
  rf_wad1  out  ADDR_WIDTH  register-file write address
  rf_wen1  out  1  register-file write enable
  rf_rad1, rf_rad2  out  ADDR_WIDTH each  register-file read addresses
  rf_ren1, rf_ren2  out  1 each  register-file read enables
  rf_dout1, rf_dout2  in  DATA_WIDTH each  register-file read data, registered, 1-cycle latency
  rf_collision  in  1  register-file collision flag
  rsp0_valid, rsp1_valid  out  1 each  read responses; rsp1_valid is only ever set together with rsp0_valid
  rsp0_data, rsp1_data  out  DATA_WIDTH each  response data; rsp0 is the older request
  err  out  1  sticky flag, set when rf_collision is seen

Function
REQ-003 Read requests SHALL enter an in-order FIFO of RQ_DEPTH entries; rd_ready = (count < RQ_DEPTH), with no credit from a same-cycle pop.
REQ-004 A write request SHALL be held in a one-entry write register (wr_pend); wr_ready = !wr_pend || write issues this cycle.
REQ-005 Per cycle, issue SHALL be decided combinationally; H0/H1 are the oldest and second-oldest queued reads.
REQ-006 H0 SHALL issue on port 1 when the queue is non-empty and freeze = 0.
REQ-007 H1 SHALL issue on port 2 when all of the following hold: H0 issues; count >= 2; H1.addr != H0.addr; and !(wr_pend && H1.addr == wr addr).
REQ-008 The pending write SHALL issue when wr_pend and !(H0 issues && H0.addr == wr addr).
REQ-009 The driven rf_* outputs SHALL never form a register-file collision: write/read and read/read addresses always differ.
REQ-010 Issued entries SHALL pop at the next posedge, 0, 1 or 2 entries; a push and a pop in the same cycle SHALL both take effect; the pointers wrap modulo RQ_DEPTH.
REQ-011 rf_* enables SHALL be 0 when not issuing; the address/data of a non-issuing port SHALL be 0.
REQ-012 Starvation counter: increments each cycle wr_pend && !write-issue; clears when the write issues or !wr_pend; saturates at STARVE_LIM.
REQ-013 freeze SHALL be 1 exactly when the counter equals STARVE_LIM; while freeze = 1, no read issues, so the write issues that cycle and the counter clears.
REQ-014 Response flags SHALL be registered: rsp0_valid/rsp1_valid at cycle N+1 equal port-1/port-2 issue at cycle N.
REQ-015 rsp0_data = rf_dout1 and rsp1_data = rf_dout2 while the matching valid is 1, else 0.
REQ-016 Read-to-response latency SHALL be 2 cycles from acceptance when the queue is empty: accept at edge A, issue in cycle A+1, response in cycle A+2.
REQ-017 Read order SHALL be preserved: responses return in acceptance order.
REQ-018 A read blocked by a same-address pending write SHALL return the pre-write value, since the read is older.
REQ-019 err SHALL set on any cycle with rf_collision = 1 and clear only on reset.
REQ-020 There SHALL be no response backpressure; the consumer samples every cycle.

Reset
REQ-021 With resetn = 0 at a posedge: FIFO empty, wr_pend = 0, starvation counter 0, rsp0_valid = rsp1_valid = 0, err = 0.
REQ-022 During reset and the first cycle after it: all rf_* outputs 0; rd_ready = 1; wr_ready = 1.
REQ-023 Reset asserted mid-operation SHALL discard all queued reads, the pending write and in-flight responses; no rsp*_valid SHALL appear in the cycle after reset.

Verification
REQ-024 Reads to addrs 3 then 7, accepted in consecutive cycles, RF preloaded 3->0xA, 7->0xB -> the first cycle with both queued issues rad1=3, rad2=7; the next cycle shows rsp0=0xA, rsp1=0xB.
REQ-025 Queued reads 5, 5 -> two separate issues on port 1; two single rsp0 responses in order.
REQ-026 Pending write addr 9 data 0x55, queued read of addr 9 -> the read issues first and returns the old value; the write issues the following cycle; a later read of 9 returns 0x55.
REQ-027 Read queue continuously refilled with addr 2, pending write to addr 2 -> after STARVE_LIM stall cycles there is one frozen cycle with rf_wen1 = 1 and rf_ren1 = rf_ren2 = 0; rd_ready drops when count = RQ_DEPTH.
REQ-028 Force rf_collision = 1 for one cycle -> err = 1 thereafter; resetn low mid-burst -> FIFO empties and the rsp*_valid flags are 0 on the following cycle.
